// File: rtl/regfile_sb.sv
// General-purpose register file with two combinational read ports, one write port,
// optional write-to-read bypass, a hardwired zero register and a pending-write scoreboard.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rn1,
    input  logic [ADDR_W-1:0] rn2,
    output logic [DATA_W-1:0] A,
    output logic [DATA_W-1:0] B,
    output logic              busy1,
    output logic              busy2,
    input  logic              write,
    input  logic [ADDR_W-1:0] wn,
    input  logic [DATA_W-1:0] wd,
    input  logic              issue,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              flush,
    output logic [ADDR_W:0]   pend_cnt,
    output logic              any_busy
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pending;

    logic wr_ok;
    logic iss_ok;
    logic set_new;
    logic clr_real;
    logic fwd1;
    logic fwd2;
    logic zero1;
    logic zero2;

    always_comb begin
        wr_ok  = write && !((ZERO_REG != 0) && (wn == '0));
        iss_ok = issue && !flush && !((ZERO_REG != 0) && (issue_rd == '0));
        // A same-register issue+write leaves the bit set, so it is not a real clear.
        set_new  = iss_ok && !pending[issue_rd];
        clr_real = wr_ok && pending[wn] && !(iss_ok && (issue_rd == wn));
    end

    always_comb begin
        zero1 = (ZERO_REG != 0) && (rn1 == '0);
        zero2 = (ZERO_REG != 0) && (rn2 == '0);
        fwd1  = (BYPASS != 0) && wr_ok && (wn == rn1);
        fwd2  = (BYPASS != 0) && wr_ok && (wn == rn2);
    end

    always_comb begin
        A = mem[rn1];
        if (zero1) begin
            A = '0;
        end else if (fwd1) begin
            A = wd;
        end
        busy1 = pending[rn1] && !fwd1 && !zero1;
    end

    always_comb begin
        B = mem[rn2];
        if (zero2) begin
            B = '0;
        end else if (fwd2) begin
            B = wd;
        end
        busy2 = pending[rn2] && !fwd2 && !zero2;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[wn] <= wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            pending  <= '0;
            pend_cnt <= '0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (iss_ok && (issue_rd == ADDR_W'(i))) begin
                    pending[i] <= 1'b1;
                end else if (wr_ok && (wn == ADDR_W'(i))) begin
                    pending[i] <= 1'b0;
                end
            end
            pend_cnt <= pend_cnt + (ADDR_W+1)'(set_new) - (ADDR_W+1)'(clr_real);
        end
    end

    assign any_busy = (pend_cnt != '0);

endmodule

// File: tb/tb_regfile_sb.sv
// Scoreboard bench for regfile_sb: stimulus pushes hand-computed expectations per cycle,
// a negedge monitor pops and compares them against both a bypass and a no-bypass instance.
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rn1, rn2, wn, issue_rd;
    logic [31:0] wd;
    logic        write, issue, flush;
    logic [31:0] A, B, A_nb, B_nb;
    logic        busy1, busy2, busy1_nb, busy2_nb;
    logic [5:0]  pend_cnt, pend_cnt_nb;
    logic        any_busy, any_busy_nb;

    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [31:0] a, b, anb;
        logic        b1, b2, any;
        logic [5:0]  cnt;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut (
        .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .A(A), .B(B),
        .busy1(busy1), .busy2(busy2), .write(write), .wn(wn), .wd(wd),
        .issue(issue), .issue_rd(issue_rd), .flush(flush),
        .pend_cnt(pend_cnt), .any_busy(any_busy)
    );

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .rn1(rn1), .rn2(rn2), .A(A_nb), .B(B_nb),
        .busy1(busy1_nb), .busy2(busy2_nb), .write(write), .wn(wn), .wd(wd),
        .issue(issue), .issue_rd(issue_rd), .flush(flush),
        .pend_cnt(pend_cnt_nb), .any_busy(any_busy_nb)
    );

    task automatic cmp(input string name, input string field,
                       input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s.%s: got 0x%08h expected 0x%08h", name, field, act, expv);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
            exp_t e;
            e = exp_q.pop_front();
            cmp(e.name, "A",        A,                e.a);
            cmp(e.name, "B",        B,                e.b);
            cmp(e.name, "busy1",    {31'd0, busy1},   {31'd0, e.b1});
            cmp(e.name, "busy2",    {31'd0, busy2},   {31'd0, e.b2});
            cmp(e.name, "pend_cnt", {26'd0, pend_cnt}, {26'd0, e.cnt});
            cmp(e.name, "any_busy", {31'd0, any_busy}, {31'd0, e.any});
            cmp(e.name, "A_nobyp",  A_nb,             e.anb);
        end
    end

    task automatic drive(input logic r, input logic [4:0] a1, input logic [4:0] a2,
                         input logic w, input logic [4:0] wa, input logic [31:0] wdat,
                         input logic is, input logic [4:0] ird, input logic fl);
        rst = r; rn1 = a1; rn2 = a2; write = w; wn = wa; wd = wdat;
        issue = is; issue_rd = ird; flush = fl;
    endtask

    task automatic expect_now(input string name, input logic [31:0] a, input logic [31:0] b,
                              input logic b1, input logic b2, input logic [5:0] cnt,
                              input logic [31:0] anb);
        exp_t e;
        e.cyc = cyc; e.name = name; e.a = a; e.b = b; e.anb = anb;
        e.b1 = b1; e.b2 = b2; e.cnt = cnt; e.any = (cnt != 6'd0);
        exp_q.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        tick;
        //     rst rn1 rn2 wr wn  wd            iss rd fl
        drive(1, 5, 31, 0, 0, 32'h0,        0, 0, 0); expect_now("reset",        0, 0, 0, 0, 0, 0); tick;
        drive(0, 3, 0,  1, 3, 32'hDEADBEEF, 0, 0, 0); expect_now("bypass_wr",    32'hDEADBEEF, 0, 0, 0, 0, 0); tick;
        drive(0, 3, 0,  0, 0, 32'h0,        0, 0, 0); expect_now("after_wr",     32'hDEADBEEF, 0, 0, 0, 0, 32'hDEADBEEF); tick;
        drive(0, 0, 3,  1, 0, 32'h1234,     1, 0, 0); expect_now("zero_wr_iss",  0, 32'hDEADBEEF, 0, 0, 0, 0); tick;
        drive(0, 0, 3,  0, 0, 32'h0,        0, 0, 0); expect_now("zero_after",   0, 32'hDEADBEEF, 0, 0, 0, 0); tick;
        drive(0, 7, 9,  0, 0, 32'h0,        1, 7, 0); expect_now("iss7",         0, 0, 0, 0, 0, 0); tick;
        drive(0, 7, 9,  0, 0, 32'h0,        1, 9, 0); expect_now("iss9",         0, 0, 1, 0, 1, 0); tick;
        drive(0, 7, 9,  1, 7, 32'h77,       0, 0, 0); expect_now("wr7_bypass",   32'h77, 0, 0, 1, 2, 0); tick;
        drive(0, 7, 9,  0, 0, 32'h0,        0, 0, 0); expect_now("after_wr7",    32'h77, 0, 0, 1, 1, 32'h77); tick;
        drive(0, 4, 9,  1, 4, 32'h55,       1, 4, 0); expect_now("iss_wr4",      32'h55, 0, 0, 1, 1, 0); tick;
        drive(0, 4, 9,  0, 0, 32'h0,        0, 0, 0); expect_now("after_iss_wr4", 32'h55, 0, 1, 1, 2, 32'h55); tick;
        drive(0, 4, 9,  1, 9, 32'h99,       0, 0, 0); expect_now("wr9",          32'h55, 32'h99, 1, 0, 2, 32'h55); tick;
        drive(0, 4, 3,  1, 3, 32'h33,       1, 4, 0); expect_now("reiss4_wr3",   32'h55, 32'h33, 1, 0, 1, 32'h55); tick;
        drive(0, 3, 4,  0, 0, 32'h0,        1, 1, 0); expect_now("iss1",         32'h33, 32'h55, 0, 1, 1, 32'h33); tick;
        drive(0, 1, 2,  0, 0, 32'h0,        1, 2, 0); expect_now("iss2",         0, 0, 1, 0, 2, 0); tick;
        drive(0, 2, 3,  0, 0, 32'h0,        1, 3, 0); expect_now("iss3",         0, 32'h33, 1, 0, 3, 0); tick;
        drive(0, 3, 6,  0, 0, 32'h0,        1, 6, 1); expect_now("flush_iss6",   32'h33, 0, 1, 0, 4, 32'h33); tick;
        drive(0, 6, 4,  0, 0, 32'h0,        0, 0, 0); expect_now("after_flush",  0, 32'h55, 0, 0, 0, 0); tick;
        drive(0, 8, 4,  1, 8, 32'h88,       0, 0, 1); expect_now("flush_wr8",    32'h88, 32'h55, 0, 0, 0, 0); tick;
        drive(0, 8, 10, 0, 0, 32'h0,        1, 10, 0); expect_now("iss10",       32'h88, 0, 0, 0, 0, 32'h88); tick;
        drive(1, 8, 10, 1, 11, 32'hBB,      1, 12, 0); expect_now("rst_mid",     32'h88, 0, 0, 1, 1, 32'h88); tick;
        drive(0, 3, 11, 0, 0, 32'h0,        0, 0, 0); expect_now("after_rst",    0, 0, 0, 0, 0, 0); tick;
        drive(0, 8, 12, 0, 0, 32'h0,        0, 0, 0); expect_now("after_rst2",   0, 0, 0, 0, 0, 0); tick;
        repeat (2) tick;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with integrated scoreboard for the pipelined CPU datapath. It provides two combinational read ports, one synchronous write port, optional write-to-read bypass and a hardwired zero register. It also tracks per-register "pending write" bits so decode can detect RAW hazards. It sits between decode (read/issue side) and writeback (write side) and supports pipeline flush.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register address width; depth = 2**ADDR_W
- ZERO_REG, 1, 1 = register 0 reads 0, is never written and is never pending
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset; synchronous, active-high
- rn1  in  ADDR_W  read address, port 1
- rn2  in  ADDR_W  read address, port 2
- A  out  DATA_W  read data, port 1
- B  out  DATA_W  read data, port 2
- busy1  out  1  register rn1 has an outstanding producer
- busy2  out  1  register rn2 has an outstanding producer
- write  in  1  writeback strobe
- wn  in  ADDR_W  writeback register address
- wd  in  DATA_W  writeback data
- issue  in  1  decode issued an instruction that writes issue_rd
- issue_rd  in  ADDR_W  destination register of the issued instruction
- flush  in  1  discard all outstanding producers
- pend_cnt  out  ADDR_W+1  number of pending registers
- any_busy  out  1  pend_cnt != 0

## Operation
- State: data[0..2**ADDR_W-1] of DATA_W bits; pending[0..2**ADDR_W-1] of 1 bit; pend_cnt counter.
- Reset (rst=1 at edge): all data cleared to 0, all pending cleared, pend_cnt = 0. rst overrides write/issue/flush.
- Reads are combinational. For port n, in priority order:
  - ZERO_REG and rn==0: output 0.
  - BYPASS and write and wn==rn (and wn!=0 if ZERO_REG): output wd.
  - Otherwise: output data[rn].
- busyN = pending[rn] and not (BYPASS and write and wn==rn). Forced 0 for register 0 when ZERO_REG.
- Write: write=1 (and wn!=0 if ZERO_REG) sets data[wn] <= wd and clears pending[wn].
- Issue: issue=1 (and issue_rd!=0 if ZERO_REG) sets pending[issue_rd].
- Issue and write to the same register in the same cycle: data is written, and pending ends set because the new producer wins.
- Flush: clears all pending bits. Issue is ignored in a flush cycle. A write in a flush cycle still updates data.
- pend_cnt tracks the population of pending:
  - +1 when a clear bit gets set.
  - -1 when a set bit gets cleared.
  - Net 0 for set+clear on different bits, or for an issue to an already-pending register.
  - 0 after flush.
  - Never wraps; maximum is 2**ADDR_W (2**ADDR_W-1 when ZERO_REG).
- Write to a non-pending register is legal; it updates data and leaves pend_cnt unchanged.

## Timing
- Read latency 0 cycles (combinational from rn1/rn2/write/wn/wd).
- Write data is visible through data[] from the cycle after the edge. With BYPASS it is visible in the same cycle.
- Pending set/clear, flush and pend_cnt/any_busy updates take effect 1 cycle after the edge.
- Reset values: A=B=0, busy1=busy2=0, pend_cnt=0, any_busy=0.
- Reset asserted mid-operation discards all in-flight issue/write in that cycle.

## Test plan
- Reset then read rn1=5, rn2=31 -> A=0, B=0, busy1=busy2=0, pend_cnt=0.
- Write wn=3, wd=0xDEADBEEF with rn1=3 in the same cycle -> A=0xDEADBEEF in that cycle (BYPASS=1); next cycle, with write low -> A=0xDEADBEEF. With BYPASS=0 -> A=0 in the write cycle.
- Write wn=0, wd=0x1234; issue issue_rd=0 -> A(rn1=0)=0, busy1=0, pend_cnt=0.
- Issue rd=7, then rd=9 -> pend_cnt 1 then 2, busy(rn=7)=1. Then write wn=7 with rn1=7 -> busy1=0 in the same cycle; next cycle pend_cnt=1.
- Same cycle: issue rd=4 and write wn=4, wd=0x55 -> next cycle data[4]=0x55, busy(rn=4)=1, pend_cnt incremented by 1.
- Issue rd=1, 2, 3, then flush together with issue rd=6 -> next cycle pend_cnt=0, any_busy=0, busy(rn=6)=0. Then assert rst mid-sequence -> all data 0 and pend_cnt=0.
